ensemble_vote_collector: RTL

- Sink end of the three-classifier ensemble: consumes the three classifier result streams (Gaussian NB, gradient boost, MLP), one label word per sample on each.
- Aligns one word from each stream, takes a 2-of-3 majority vote, and emits one voted result word per sample on a single AXI-Stream master.
- Keeps a wrap-around sample counter and a sticky stream-misalignment flag for the host.

---
 rtl/ensemble_vote_collector.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ensemble_vote_collector.sv
// Purpose : aligns one label word from each of three classifier streams and emits a 2-of-3 majority-voted result word.
// Latency : result valid 1 cycle after the last of the three input captures; at most one result every 2 cycles.
// Backpressure: m_axis_tready low holds the result stable and blocks every input until the handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_*_0/1/2                classifier label streams (tdata[CLASS_W-1:0] = label, tkeep ignored)
//   m_axis_*                      voted result stream (tkeep constant all-ones)
//   sample_count                  results accepted downstream, modulo 2^16
//   misalign_err                  sticky: captured tlasts of some sample disagreed
module ensemble_vote_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int CLASS_W    = 8,
    parameter int TIE_SEL    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
    input  logic                  s_axis_tvalid_0,
    output logic                  s_axis_tready_0,
    input  logic                  s_axis_tlast_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [15:0]           sample_count,
    output logic                  misalign_err
);

    typedef enum logic {
        ST_COLLECT,
        ST_EMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              hold_q, hold_d;
    logic [CLASS_W-1:0]      label_q [3];
    logic [CLASS_W-1:0]      label_d [3];
    logic [2:0]              last_q, last_d;
    logic                    out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0]   out_dat_q, out_dat_d;
    logic                    out_last_q, out_last_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    mis_q, mis_d;

    logic [2:0]              in_vld;
    logic [2:0]              in_last;
    logic [CLASS_W-1:0]      in_label [3];
    logic [2:0]              in_rdy;
    logic [2:0]              take;
    logic [2:0]              hold_cap;

    logic [CLASS_W-1:0]      vote_label;
    logic [1:0]              vote_cnt;
    logic                    vote_tie;
    logic                    vote_mis;
    logic [DATA_WIDTH-1:0]   vote_word;

    // tkeep and label-upper bits carry nothing this block uses.
    logic unused_ok;
    assign unused_ok = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                         s_axis_tdata_0[DATA_WIDTH-1:CLASS_W],
                         s_axis_tdata_1[DATA_WIDTH-1:CLASS_W],
                         s_axis_tdata_2[DATA_WIDTH-1:CLASS_W]};

    assign in_vld      = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign in_last     = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
    assign in_label[0] = s_axis_tdata_0[CLASS_W-1:0];
    assign in_label[1] = s_axis_tdata_1[CLASS_W-1:0];
    assign in_label[2] = s_axis_tdata_2[CLASS_W-1:0];

    // Readies depend only on registered state, so a source sees a stable ready all cycle.
    assign in_rdy   = (state_q == ST_COLLECT) ? ~hold_q : 3'b000;
    assign take     = in_vld & in_rdy;
    assign hold_cap = hold_q | take;

    assign s_axis_tready_0 = in_rdy[0];
    assign s_axis_tready_1 = in_rdy[1];
    assign s_axis_tready_2 = in_rdy[2];

    // Holding registers after this cycle's captures; the vote looks at these so the
    // result can be registered on the same edge as the final capture.
    always_comb begin
        label_d = label_q;
        last_d  = last_q;
        for (int i = 0; i < 3; i++) begin
            if (take[i]) begin
                label_d[i] = in_label[i];
                last_d[i]  = in_last[i];
            end
        end
    end

    always_comb begin
        vote_label = label_d[TIE_SEL];
        vote_cnt   = 2'd1;
        vote_tie   = 1'b1;
        if (label_d[0] == label_d[1]) begin
            vote_label = label_d[0];
            vote_cnt   = (label_d[0] == label_d[2]) ? 2'd3 : 2'd2;
            vote_tie   = 1'b0;
        end else if (label_d[0] == label_d[2]) begin
            vote_label = label_d[0];
            vote_cnt   = 2'd2;
            vote_tie   = 1'b0;
        end else if (label_d[1] == label_d[2]) begin
            vote_label = label_d[1];
            vote_cnt   = 2'd2;
            vote_tie   = 1'b0;
        end
        vote_mis = (|last_d) & ~(&last_d);

        vote_word                = '0;
        vote_word[CLASS_W-1:0]   = vote_label;
        vote_word[17:16]         = vote_cnt;
        vote_word[24]            = vote_tie;
        vote_word[25]            = vote_mis;
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        cnt_d      = cnt_q;
        mis_d      = mis_q;
        case (state_q)
            ST_COLLECT: begin
                hold_d = hold_cap;
                if (&hold_cap) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = vote_word;
                    out_last_d = &last_d;
                    mis_d      = mis_q | vote_mis;
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (m_axis_tready) begin
                    hold_d    = 3'b000;
                    out_vld_d = 1'b0;
                    cnt_d     = cnt_q + 16'd1;
                    state_d   = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            hold_q     <= 3'b000;
            last_q     <= 3'b000;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            cnt_q      <= 16'd0;
            mis_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                label_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
            cnt_q      <= cnt_d;
            mis_q      <= mis_d;
            for (int i = 0; i < 3; i++) begin
                label_q[i] <= label_d[i];
            end
        end
    end

    assign m_axis_tdata  = out_dat_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_last_q;
    assign sample_count  = cnt_q;
    assign misalign_err  = mis_q;

endmodule
